modular_subtraction: RTL
========================

// Module: modular_subtraction
// PURPOSE
//   Computes R = (A - B) mod p for operands A, B < p, the inverse of the modular adder.
//   It is a limb-serial, constant-time datapath with a start/done handshake and sits
//   beside modular_addition in the field-arithmetic unit. Phase 1 forms A - B with a
//   borrow chain. Phase 2 always adds (p AND borrow-mask), so no timing depends on data.
// PARAMETERS
//   WIDTH  256  operand/modulus width in bits
//   LIMB   64   bits processed per cycle; WIDTH % LIMB == 0; NLIMB = WIDTH/LIMB
// PORTS
//   i_clk     in   1      clock, rising edge
//   i_rst     in   1      synchronous reset, active-high
//   i_start   in   1      request; sampled only when o_busy==0
//   i_a       in   WIDTH  minuend A, must be < i_p
//   i_b       in   WIDTH  subtrahend B, must be < i_p
//   i_p       in   WIDTH  modulus p, nonzero
//   o_result  out  WIDTH  (A - B) mod p; valid when o_done==1, held until next o_done
//   o_done    out  1      one-cycle pulse, result valid
//   o_busy    out  1      high from the cycle after start acceptance through the o_done cycle
// BEHAVIOUR
//   Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
//   Reset values: state=IDLE; o_result=0; o_done=0; o_busy=0; internal regs=0.
//   States: IDLE -> SUB -> CORR -> DONE -> IDLE.
//   IDLE: on i_start=1, latch i_a, i_b and i_p; clear borrow; limb_cnt=0; go to SUB.
//   SUB: one limb per cycle, low limb first.
//     {bw, d[k]} = a[k] - b[k] - bw.
//     After NLIMB cycles, latch neg = final bw, clear carry, limb_cnt=0, go to CORR.
//   CORR: one limb per cycle. {cy, d[k]} = d[k] + (p[k] & {LIMB{neg}}) + cy.
//     Final carry is discarded (mod 2^WIDTH). After NLIMB cycles, go to DONE.
//   DONE: o_result <= d; o_done=1 for exactly this cycle; next state is IDLE.
//   Latency: i_start sampled at edge T, so o_done is high in the cycle after edge T+2*NLIMB.
//     That is 2*NLIMB+1 cycles (9 at default), independent of the data.
//   Throughput: a new i_start is accepted in the first IDLE cycle after DONE,
//     i.e. one operation per 2*NLIMB+2 cycles.
//   i_start while o_busy=1: ignored, with no effect on the operation in flight.
//   Input changes after acceptance: ignored, because operands are latched.
//   Out-of-range inputs (A>=p or B>=p): no error is flagged.
//     Output = raw two-phase result mod 2^WIDTH, with no further reduction.
//   A==B: neg=0 and the result is 0.
//   A<B: neg=1 and the result is A-B+p.
//   Reset mid-operation: aborts on the next edge, all outputs return to reset values,
//     and no o_done is issued for the aborted request.
//   Simultaneous i_rst and i_start: reset wins and the start is dropped.
// TESTING
//   1 p=13, A=10, B=3, pulse i_start -> o_done exactly 9 cycles later, o_result=7.
//   2 p=13, A=3, B=10 -> o_result=6 (borrow path), with the same 9-cycle latency as test 1.
//   3 p=2^255-19, A=B=0x1234_5678 -> o_result=0; o_busy low again one cycle after o_done.
//   4 p=2^255-19, A=2^64, B=1 -> o_result=0xFFFF_FFFF_FFFF_FFFF (borrow across limb 0/1).
//     Then A=0, B=1 -> p-1 (full-width correction carry).
//   5 Pulse i_start again mid-operation with different operands -> first result unchanged
//     and only one o_done. Then assert i_rst in the CORR phase -> no o_done,
//     o_result=0, o_busy=0, and the next start completes normally.
//   6 p=secp256k1 prime: 10k random A, B < p checked against a reference model
//     ((A-B)%p). Every o_done matches, the latency is always 9, and o_done is a single pulse.

Source files
------------

// File: rtl/modular_subtraction.sv
// Limb-serial constant-time modular subtractor: R = (A - B) mod p.
// A borrow-chain pass is always followed by a correction pass that adds p masked by the final borrow.
module modular_subtraction #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned LIMB  = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_busy
);

  localparam int unsigned NLIMB = WIDTH / LIMB;
  localparam int unsigned CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [1:0] {IDLE, SUB, CORR, DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, p_q, d_q, result_q;
  logic [CW-1:0]     cnt_q;
  logic              bw_q, cy_q, neg_q;

  logic [LIMB:0]     sub_w, add_w;
  logic [LIMB-1:0]   limb_in;
  logic [WIDTH-1:0]  limb_ext, d_d;
  logic              last_limb;

  assign last_limb = (cnt_q == CW'(NLIMB - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_start)   state_d = SUB;
      SUB:  if (last_limb) state_d = CORR;
      CORR: if (last_limb) state_d = DONE;
      DONE:                state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    o_done   = (state_q == DONE);
    o_busy   = (state_q != IDLE);
    o_result = result_q;
  end

  // The low limb of each operand register is the active one; d fills from the top
  // so after NLIMB shifts it holds the full word in natural order.
  always_comb begin
    sub_w    = {1'b0, a_q[LIMB-1:0]} - {1'b0, b_q[LIMB-1:0]} - {{LIMB{1'b0}}, bw_q};
    add_w    = {1'b0, d_q[LIMB-1:0]} + {1'b0, p_q[LIMB-1:0] & {LIMB{neg_q}}}
             + {{LIMB{1'b0}}, cy_q};
    limb_in  = (state_q == SUB) ? sub_w[LIMB-1:0] : add_w[LIMB-1:0];
    limb_ext = '0;
    limb_ext[LIMB-1:0] = limb_in;
    d_d      = (d_q >> LIMB) | (limb_ext << (WIDTH - LIMB));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      d_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      cy_q     <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            a_q   <= i_a;
            b_q   <= i_b;
            p_q   <= i_p;
            bw_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        SUB: begin
          a_q   <= a_q >> LIMB;
          b_q   <= b_q >> LIMB;
          d_q   <= d_d;
          bw_q  <= sub_w[LIMB];
          cnt_q <= cnt_q + 1'b1;
          if (last_limb) begin
            neg_q <= sub_w[LIMB];
            cy_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        CORR: begin
          p_q   <= p_q >> LIMB;
          d_q   <= d_d;
          cy_q  <= add_w[LIMB];
          cnt_q <= cnt_q + 1'b1;
          // Result is captured on the final correction edge so it is valid alongside o_done.
          if (last_limb) begin
            result_q <= d_d;
            cnt_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
